// File: rtl/sqrt_batch_engine.sv
// Batch square-root engine: operands are loaded into an internal memory, then a batch walks
// addresses 0..Last_Addr and emits floor(sqrt) per element. Optional SQRT_REMAINDER_EN adds Out_Rem.
module sqrt_batch_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Wr_En,
  input  logic [ADDR_W-1:0]     Wr_Addr,
  input  logic [DATA_W-1:0]     Wr_Data,
  input  logic                  St,
  input  logic [ADDR_W-1:0]     Last_Addr,
  output logic                  Busy,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [ADDR_W-1:0]     Out_Addr,
  output logic [DATA_W-1:0]     Out_N,
  output logic [DATA_W/2-1:0]   Out_Sqrt,
  output logic                  Done,
  output logic [2:0]            Dbg_State
`ifdef SQRT_REMAINDER_EN
  ,
  output logic [DATA_W/2:0]     Out_Rem
`endif
);

  localparam int H  = DATA_W / 2;
  localparam int CW = $clog2(H) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [H-1:0]      root_q, root_d;
  logic [H+1:0]      rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;
  logic              wr_fire;

  logic [H+1:0]      trial;
  logic [H+1:0]      sub;
  logic              ge;

  assign wr_fire = Wr_En && (state_q == S_IDLE);

  // Memory is never reset so operands survive an aborted batch; read port is registered.
  always_ff @(posedge CLK) begin
    if (wr_fire) mem_q[Wr_Addr] <= Wr_Data;
    rd_q <= mem_q[ptr_q];
  end

  // Restoring step: bring down the next operand bit pair and try to subtract 4*root+1.
  assign trial = (rem_q << 2) | {{H{1'b0}}, x_q[DATA_W-1 -: 2]};
  assign sub   = {root_q, 2'b01};
  assign ge    = (trial >= sub);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    n_d     = n_q;
    x_d     = x_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (St) begin
          last_d  = Last_Addr;
          ptr_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        n_d     = rd_q;
        x_d     = rd_q;
        root_d  = '0;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        root_d = {root_q[H-2:0], ge};
        rem_d  = ge ? (trial - sub) : trial;
        x_d    = x_q << 2;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_OUT;
      end
      // Result holds in OUT until Out_Valid && Out_Ready on a rising edge; only then does
      // the pointer advance, so every element is transferred exactly once.
      S_OUT: begin
        if (Out_Ready) begin
          if (ptr_q == last_q) begin
            state_d = S_FIN;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      n_q     <= '0;
      x_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      n_q     <= n_d;
      x_q     <= x_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Out_Valid = (state_q == S_OUT);
  assign Done      = (state_q == S_FIN);
  assign Out_Addr  = ptr_q;
  assign Out_N     = n_q;
  assign Out_Sqrt  = root_q;
  assign Dbg_State = state_q;

`ifdef SQRT_REMAINDER_EN
  assign Out_Rem = rem_q[H:0];
`endif

endmodule

// File: tb/tb_sqrt_batch_engine.sv
// Bench for sqrt_batch_engine: scoreboard of expected results pushed at batch start and
// popped at each output handshake; a second 16-bit instance covers the wide configuration.
module tb_sqrt_batch_engine;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int HW  = DW / 2;
  localparam int DW2 = 16;
  localparam int AW2 = 2;
  localparam int HW2 = DW2 / 2;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Wr_En;
  logic [AW-1:0] Wr_Addr;
  logic [DW-1:0] Wr_Data;
  logic          St;
  logic [AW-1:0] Last_Addr;
  logic          Busy;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [AW-1:0] Out_Addr;
  logic [DW-1:0] Out_N;
  logic [HW-1:0] Out_Sqrt;
  logic          Done;
  logic [2:0]    dbg_state;

  logic           wr_en16;
  logic [AW2-1:0] wr_addr16;
  logic [DW2-1:0] wr_data16;
  logic           st16;
  logic [AW2-1:0] last16;
  logic           busy16;
  logic           valid16;
  logic           ready16;
  logic [AW2-1:0] addr16;
  logic [DW2-1:0] n16;
  logic [HW2-1:0] sqrt16;
  logic           done16;
  logic [2:0]     dbg16;
`ifdef SQRT_REMAINDER_EN
  logic [HW:0]    Out_Rem;
  logic [HW2:0]   rem16;
`endif

  sqrt_batch_engine #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .CLK(CLK), .Reset(Reset), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .St(St), .Last_Addr(Last_Addr), .Busy(Busy), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Addr(Out_Addr), .Out_N(Out_N), .Out_Sqrt(Out_Sqrt),
    .Done(Done), .Dbg_State(dbg_state)
`ifdef SQRT_REMAINDER_EN
    , .Out_Rem(Out_Rem)
`endif
  );

  sqrt_batch_engine #(.DATA_W(DW2), .ADDR_W(AW2)) u_dut16 (
    .CLK(CLK), .Reset(Reset), .Wr_En(wr_en16), .Wr_Addr(wr_addr16), .Wr_Data(wr_data16),
    .St(st16), .Last_Addr(last16), .Busy(busy16), .Out_Valid(valid16),
    .Out_Ready(ready16), .Out_Addr(addr16), .Out_N(n16), .Out_Sqrt(sqrt16),
    .Done(done16), .Dbg_State(dbg16)
`ifdef SQRT_REMAINDER_EN
    , .Out_Rem(rem16)
`endif
  );

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [AW+DW+HW-1:0] exp_q[$];
  logic [DW-1:0]       mem_m [2**AW];

  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic write_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Wr_En = 1'b1; Wr_Addr = a; Wr_Data = d;
    mem_m[a] = d;
    @(negedge CLK);
    Wr_En = 1'b0;
  endtask

  task automatic start_batch(input logic [AW-1:0] last);
    logic [AW-1:0] a;
    St = 1'b1; Last_Addr = last;
    for (int i = 0; i <= int'(last); i++) begin
      a = AW'(i);
      exp_q.push_back({a, mem_m[a], HW'(isqrt(int'(mem_m[a])))});
    end
    @(negedge CLK);
    St = 1'b0;
  endtask

  // Consumes one batch; called at the first negedge after the St edge.
  task automatic drain(input int exp_count, input int stall_idx, input int stall_len,
                       input bit noise);
    int got = 0, cyc = 0, stall = 0, last_hs = -1, exp_cyc;
    bit prev_valid = 0, finished = 0;
    logic [AW+DW+HW-1:0] e;
    Out_Ready = 1'b1;
    while (!finished && cyc < 3000) begin
      if (prev_valid && !Out_Valid) begin
        total_cnt++;
        $display("FAIL valid_dropped: Out_Valid=0 required 1 at cyc %0d", cyc);
        prev_valid = 0;
      end
      if (Out_Valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL extra_result: addr=%0d required none", Out_Addr);
          e = '0;
        end else begin
          e = exp_q[0];
        end
        if (!prev_valid) begin
          exp_cyc = (last_hs < 0) ? HW + 2 : last_hs + HW + 3;
          total_cnt++;
          if (cyc !== exp_cyc) $display("FAIL latency: valid at cyc %0d required %0d", cyc, exp_cyc);
          else pass_cnt++;
        end
        total_cnt++;
        if ({Out_Addr, Out_N, Out_Sqrt} !== e)
          $display("FAIL result: addr=%0d n=%0d sqrt=%0d required addr=%0d n=%0d sqrt=%0d",
                   Out_Addr, Out_N, Out_Sqrt, e[AW+DW+HW-1 -: AW], e[DW+HW-1 -: DW], e[HW-1:0]);
        else pass_cnt++;
        total_cnt++;
        if (Busy !== 1'b1) $display("FAIL busy_in_out: Busy=%b required 1", Busy);
        else pass_cnt++;
`ifdef SQRT_REMAINDER_EN
        total_cnt++;
        if (int'(Out_Rem) !== int'(e[DW+HW-1 -: DW]) - int'(e[HW-1:0]) * int'(e[HW-1:0]))
          $display("FAIL rem: Out_Rem=%0d for n=%0d", Out_Rem, e[DW+HW-1 -: DW]);
        else pass_cnt++;
`endif
        if (got == stall_idx && stall < stall_len) begin
          Out_Ready = 1'b0; stall++;
        end else begin
          Out_Ready = 1'b1;
        end
        if (Out_Ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          got++; last_hs = cyc; prev_valid = 0;
        end else begin
          prev_valid = 1;
        end
      end else begin
        Out_Ready = 1'b1;
      end
      if (Done) finished = 1;
      if (noise && Busy && !Done) begin
        Wr_En = 1'b1; Wr_Addr = AW'($urandom_range(0, 2**AW - 1)); Wr_Data = DW'($urandom);
        St = $urandom_range(0, 1) == 1; Last_Addr = AW'($urandom_range(0, 2**AW - 1));
      end else begin
        Wr_En = 1'b0; St = 1'b0;
      end
      @(negedge CLK); cyc++;
    end
    Wr_En = 1'b0; St = 1'b0;
    total_cnt++;
    if (!finished) $display("FAIL batch_timeout: no Done after %0d cycles", cyc);
    else pass_cnt++;
    total_cnt++;
    if (got !== exp_count) $display("FAIL result_count: got %0d required %0d", got, exp_count);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if ({Done, Busy} !== 2'b00) $display("FAIL done_pulse: Done=%b Busy=%b required 0 0", Done, Busy);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Wr_En = 0; Wr_Addr = '0; Wr_Data = '0; St = 0; Last_Addr = '0; Out_Ready = 1;
    wr_en16 = 0; wr_addr16 = '0; wr_data16 = '0; st16 = 0; last16 = '0; ready16 = 1;
    repeat (3) @(negedge CLK);
    total_cnt++;
    if ({Busy, Out_Valid, Done, Out_Addr, Out_N, Out_Sqrt} !== '0)
      $display("FAIL reset_values: busy=%b valid=%b done=%b addr=%0d n=%0d sqrt=%0d required all 0",
               Busy, Out_Valid, Done, Out_Addr, Out_N, Out_Sqrt);
    else pass_cnt++;
    Reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [8];
    vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd15, 8'd16, 8'd255};
    for (int i = 0; i < 8; i++) write_mem(AW'(i), vals[i]);
    start_batch(AW'(7));
    drain(8, -1, 0, 0);
  endtask

  task automatic test_stall();
    start_batch(AW'(7));
    drain(8, 2, 10, 0);
  endtask

  task automatic test_write_and_start();
    logic [DW-1:0] d;
    d = mem_m[0] ^ 8'hA5;
    Wr_En = 1'b1; Wr_Addr = '0; Wr_Data = d;
    mem_m[0] = d;
    start_batch(AW'(0));
    Wr_En = 1'b0;
    drain(1, -1, 0, 0);
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 2**AW; i++) write_mem(AW'(i), DW'($urandom_range(0, 255)));
    write_mem(AW'(5), 8'd200);
    write_mem(AW'(15), 8'd255);
    start_batch(AW'(15));
    drain(16, -1, 0, 1);
    start_batch(AW'(15));
    drain(16, 7, 3, 0);
  endtask

  task automatic test_reset_midbatch();
    int cyc = 0;
    start_batch(AW'(7));
    Out_Ready = 1'b1;
    while (!(dbg_state == 3'd3 && Out_Addr == AW'(3)) && cyc < 500) begin
      @(negedge CLK); cyc++;
    end
    total_cnt++;
    if (cyc >= 500) $display("FAIL reach_calc3: timeout after %0d cycles", cyc);
    else pass_cnt++;
    #2 Reset = 1'b1;
    #1;
    total_cnt++;
    if ({Busy, Out_Valid, Done, Out_Addr, Out_N, Out_Sqrt} !== '0)
      $display("FAIL async_reset: busy=%b valid=%b done=%b addr=%0d n=%0d sqrt=%0d required all 0",
               Busy, Out_Valid, Done, Out_Addr, Out_N, Out_Sqrt);
    else pass_cnt++;
    exp_q.delete();
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    start_batch(AW'(1));
    drain(2, -1, 0, 0);
  endtask

  task automatic test_wide();
    int cyc = 0, first_cyc = -1;
    logic [DW2-1:0] ops [2];
    ops = '{16'd65535, 16'd40000};
    for (int i = 0; i < 2; i++) begin
      wr_en16 = 1'b1; wr_addr16 = AW2'(i); wr_data16 = ops[i];
      @(negedge CLK);
    end
    wr_en16 = 1'b0;
    st16 = 1'b1; last16 = AW2'(1);
    @(negedge CLK);
    st16 = 1'b0; ready16 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      while (!valid16 && cyc < 200) begin
        @(negedge CLK); cyc++;
      end
      total_cnt++;
      if (!valid16) $display("FAIL wide_timeout: element %0d never valid", k);
      else pass_cnt++;
      total_cnt++;
      if (k == 0 && cyc !== HW2 + 2) $display("FAIL wide_latency: valid at %0d required %0d", cyc, HW2 + 2);
      else if (k == 1 && cyc - first_cyc !== HW2 + 3)
        $display("FAIL wide_period: gap %0d required %0d", cyc - first_cyc, HW2 + 3);
      else pass_cnt++;
      total_cnt++;
      if (n16 !== ops[k] || sqrt16 !== HW2'(isqrt(int'(ops[k]))) || addr16 !== AW2'(k))
        $display("FAIL wide_result: addr=%0d n=%0d sqrt=%0d required addr=%0d n=%0d sqrt=%0d",
                 addr16, n16, sqrt16, k, ops[k], isqrt(int'(ops[k])));
      else pass_cnt++;
`ifdef SQRT_REMAINDER_EN
      total_cnt++;
      if (int'(rem16) !== int'(ops[k]) - isqrt(int'(ops[k])) * isqrt(int'(ops[k])))
        $display("FAIL wide_rem: rem=%0d for n=%0d", rem16, ops[k]);
      else pass_cnt++;
`endif
      first_cyc = cyc;
      @(negedge CLK); cyc++;
    end
    total_cnt++;
    if (done16 !== 1'b1) $display("FAIL wide_done: Done=%b required 1", done16);
    else pass_cnt++;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_write_and_start();
    test_full_depth();
    test_reset_midbatch();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sqrt_batch_engine.md
SQRT_BATCH_ENGINE -- requirements
Module: sqrt_batch_engine

Interface
REQ-001 Parameter DATA_W, 8, operand width; SHALL be even and >= 4.
REQ-002 Parameter ADDR_W, 4, operand-memory address width; depth = 2**ADDR_W words.
REQ-003 CLK  input  1  sole clock, all state on rising edge.
REQ-004 Reset  input  1  reset is asynchronous and active-high.
REQ-005 Wr_En  input  1  operand-memory write strobe.
REQ-006 Wr_Addr  input  ADDR_W  write address.
REQ-007 Wr_Data  input  DATA_W  operand to store.
REQ-008 St  input  1  batch start request.
REQ-009 Last_Addr  input  ADDR_W  final address of batch, sampled with St.
REQ-010 Busy  output  1  batch in progress.
REQ-011 Out_Valid  output  1  result available.
REQ-012 Out_Ready  input  1  consumer accepts result.
REQ-013 Out_Addr  output  ADDR_W  address of current result.
REQ-014 Out_N  output  DATA_W  operand of current result.
REQ-015 Out_Sqrt  output  DATA_W/2  floor(sqrt(Out_N)).
REQ-016 Done  output  1  one-cycle pulse at batch end.

Function
REQ-017 Internal operand memory: 2**ADDR_W x DATA_W, synchronous write, synchronous read (1-cycle latency), inferable as block RAM.
REQ-018 FSM states IDLE, READ, LOAD, CALC, OUT, FIN.
REQ-019 IDLE: Wr_En=1 writes Wr_Data to Wr_Addr; St=1 captures Last_Addr, sets address pointer to 0, -> READ.
REQ-020 Wr_En SHALL be ignored in every state except IDLE; St SHALL be ignored while Busy=1.
REQ-021 St and Wr_En asserted together in IDLE: write performed and batch started same cycle; address 0 written that cycle SHALL be read with the new value.
REQ-022 READ: present pointer to memory, -> LOAD; LOAD: latch memory output into operand register, clear root/remainder, -> CALC.
REQ-023 CALC: restoring digit-by-digit square root, one result bit per cycle, MSB first, exactly DATA_W/2 cycles; remainder register DATA_W/2+2 bits, no truncation.
REQ-024 OUT: Out_Valid=1, Out_Addr/Out_N/Out_Sqrt stable until Out_Valid&&Out_Ready; no result dropped or duplicated.
REQ-025 On handshake: if pointer==captured Last_Addr -> FIN, else pointer+1, -> READ.
REQ-026 Per-element latency St/handshake to Out_Valid = DATA_W/2 + 2 cycles; with Out_Ready held 1, one result every DATA_W/2 + 3 cycles.
REQ-027 FIN: Done=1 for exactly one cycle, -> IDLE; Busy=0 in IDLE only.
REQ-028 Last_Addr = 2**ADDR_W-1 processes full depth; pointer SHALL NOT wrap past Last_Addr; Last_Addr=0 processes one element.
REQ-029 Operand 0 -> Out_Sqrt 0; operand 2**DATA_W-1 -> Out_Sqrt 2**(DATA_W/2)-1.

Reset
REQ-030 Reset=1 at any time, including mid-batch, SHALL force IDLE within the same cycle (asynchronously).
REQ-031 Reset values: Busy=0, Out_Valid=0, Done=0, Out_Addr=0, Out_N=0, Out_Sqrt=0, pointer=0.
REQ-032 Operand memory contents SHALL NOT be cleared by Reset.

Configuration
REQ-033 Macro SQRT_REMAINDER_EN: when defined, add output Out_Rem (DATA_W/2+1 bits) = Out_N - Out_Sqrt**2, valid with Out_Valid, reset value 0.
REQ-034 Without SQRT_REMAINDER_EN: port Out_Rem absent, all other behaviour and timing identical.

Verification
REQ-035 DATA_W=8: write 0,1,2,3,4,15,16,255 to addr 0-7, St with Last_Addr=7, Out_Ready=1 -> Out_Sqrt 0,1,1,1,2,3,4,15 in address order, one Done pulse.
REQ-036 Out_Ready=0 for 10 cycles on element 2 -> Out_Valid held, outputs stable, no element skipped; total 8 results.
REQ-037 Reset asserted during CALC of element 3 -> all outputs 0 next edge; re-St with Last_Addr=1 returns results for addr 0,1 from retained memory.
REQ-038 Wr_En and St during Busy -> no memory change, batch unaffected; full-depth Last_Addr=15 yields exactly 16 results, no wrap.
REQ-039 SQRT_REMAINDER_EN defined: operand 255 -> Out_Sqrt 15, Out_Rem 30; operand 200 -> 14, Rem 4.
REQ-040 DATA_W=16: operand 65535 -> Out_Sqrt 255 after 10 cycles from St; operand 40000 -> 200.
